rca_share_scheduler: RTL and testbench

//  Round-robin scheduler sharing one WIDTH-bit ripple carry adder among NUM_REQ requesters.

---
 rtl/rca_share_scheduler.sv | 172 +++++++++++++++++
 tb/tb_rca_share_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_share_scheduler.sv
// rca_share_scheduler: round-robin arbiter that time-shares one external
// ripple carry adder among NUM_REQ requesters. The winning request's operands
// are registered onto the adder inputs. The carry chain is given SETTLE_CYC
// cycles to ripple before sum/carry are captured. The result, tagged with
// the owner's ID, is held on a valid/ready response port until it is taken.
module rca_share_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 64,
    parameter int SETTLE_CYC = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]       req_cin_i,
    input  logic [NUM_REQ-1:0]       req_sub_i,
    output logic [WIDTH-1:0]         add_a_o,
    output logic [WIDTH-1:0]         add_b_o,
    output logic                     add_cin_o,
    input  logic [WIDTH-1:0]         add_s_i,
    input  logic                     add_cout_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [ID_W-1:0]          rsp_id_o,
    output logic [WIDTH-1:0]         rsp_sum_o,
    output logic                     rsp_cout_o,
    output logic                     rsp_ovf_o,
    output logic                     busy_o
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic               add_cin_q, add_cin_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
    logic               rsp_cout_q, rsp_cout_d;
    logic               rsp_ovf_q, rsp_ovf_d;

    logic               gnt_found;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    scan_idx;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic               cin_sel;
    logic               sub_sel;

    // Round-robin search: first valid requester strictly after the last winner, with wrap
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid_i[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = scan_idx;
            end
        end
    end

    // Operand mux for the current round-robin winner
    always_comb begin
        a_sel   = req_a_i[int'(gnt_id)*WIDTH +: WIDTH];
        b_sel   = req_b_i[int'(gnt_id)*WIDTH +: WIDTH];
        cin_sel = req_cin_i[gnt_id];
        sub_sel = req_sub_i[gnt_id];
    end

    // Next-state logic: grant in IDLE, count down the ripple time, then hold the result
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_ovf_d   = rsp_ovf_q;
        req_ready_o = '0;
        case (state_q)
            IDLE: begin
                if (gnt_found && !rst_i) begin
                    req_ready_o[gnt_id] = 1'b1;
                    add_a_d   = a_sel;
                    add_b_d   = sub_sel ? ~b_sel : b_sel;
                    add_cin_d = sub_sel | cin_sel;
                    id_d      = gnt_id;
                    rr_d      = gnt_id;
                    cnt_d     = CNT_W'(SETTLE_CYC - 1);
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_sum_d   = add_s_i;
                    rsp_cout_d  = add_cout_i;
                    rsp_ovf_d   = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                                  (add_s_i[WIDTH-1] != add_a_q[WIDTH-1]);
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_q        <= ID_W'(NUM_REQ - 1);
            cnt_q       <= '0;
            id_q        <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;
    assign add_cin_o   = add_cin_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = id_q;
    assign rsp_sum_o   = rsp_sum_q;
    assign rsp_cout_o  = rsp_cout_q;
    assign rsp_ovf_o   = rsp_ovf_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_rca_share_scheduler.sv
// Testbench for rca_share_scheduler: a behavioural adder stands in for the RCA,
// per-requester operand queues drive the request ports, and a scoreboard of
// hand-computed responses is checked by an independent monitor.
module tb_rca_share_scheduler;

    localparam int NUM_REQ    = 4;
    localparam int WIDTH      = 64;
    localparam int SETTLE_CYC = 4;
    localparam int ID_W       = 2;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_cin;
    logic [NUM_REQ-1:0]       req_sub;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic                     add_cin;
    logic [WIDTH-1:0]         add_s;
    logic                     add_cout;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_sum;
    logic                     rsp_cout;
    logic                     rsp_ovf;
    logic                     busy;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
    } op_t;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    op_t  pend[NUM_REQ][$];
    exp_t expQ[$];
    int   grantCyc[$];
    int   grantCount[NUM_REQ];
    int   cycle;
    int   nCompared;
    int   nMismatch;

    rca_share_scheduler #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .SETTLE_CYC(SETTLE_CYC), .ID_W(ID_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_cin_i(req_cin), .req_sub_i(req_sub),
        .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin),
        .add_s_i(add_s), .add_cout_i(add_cout),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_sum_o(rsp_sum), .rsp_cout_o(rsp_cout),
        .rsp_ovf_o(rsp_ovf), .busy_o(busy)
    );

    // Behavioural ripple carry adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", nCompared);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: actual=%h expected=%h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub, input logic [WIDTH-1:0] sum,
                                 input logic cout, input logic ovf);
        op_t  op;
        exp_t e;
        op.a = a; op.b = b; op.cin = cin; op.sub = sub;
        e.id = id; e.sum = sum; e.cout = cout; e.ovf = ovf;
        pend[id].push_back(op);
        expQ.push_back(e);
    endtask

    function automatic bit allPendEmpty();
        bit empty;
        empty = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i].size() != 0) empty = 1'b0;
        end
        return empty;
    endfunction

    task automatic waitDone(input string name, input int bound);
        int n;
        n = 0;
        while (n < bound && !(allPendEmpty() && expQ.size() == 0 && !busy && req_valid == '0)) begin
            @(negedge clk);
            n++;
        end
        nCompared++;
        if (n >= bound) begin
            nMismatch++;
            $display("[TB] FAIL %s_timeout: pending=%0d expected=0 after %0d cycles", name, expQ.size(), bound);
        end
    endtask

    // Request driver: present the head of each requester's queue, retire it once granted
    initial begin
        int consumed[NUM_REQ];
        for (int i = 0; i < NUM_REQ; i++) consumed[i] = 0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_sub   = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                while (consumed[i] < grantCount[i]) begin
                    consumed[i]++;
                    if (pend[i].size() > 0) void'(pend[i].pop_front());
                end
                if (pend[i].size() > 0) begin
                    req_valid[i]               = 1'b1;
                    req_a[i*WIDTH +: WIDTH]    = pend[i][0].a;
                    req_b[i*WIDTH +: WIDTH]    = pend[i][0].b;
                    req_cin[i]                 = pend[i][0].cin;
                    req_sub[i]                 = pend[i][0].sub;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Grant observer: one-hot single-cycle ready pulses, only from IDLE
    initial begin
        logic prevNz;
        prevNz = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) grantCount[i] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevNz = 1'b0;
            end else begin
                if (req_ready != '0) begin
                    checkOutput("ready_onehot", 64'($onehot(req_ready)), 64'd1);
                    checkOutput("ready_single_cycle", 64'(prevNz), 64'd0);
                    checkOutput("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (req_ready[i]) grantCount[i]++;
                    end
                    grantCyc.push_back(cycle);
                end
                if (busy && req_valid != '0) checkOutput("ready_while_busy", 64'(req_ready), 64'd0);
                prevNz = (req_ready != '0);
            end
        end
    end

    // Response monitor: latency, hold-while-stalled, and scoreboard comparison on handshake
    initial begin
        logic             prevValid;
        logic             prevHs;
        logic [ID_W-1:0]  snapId;
        logic [WIDTH-1:0] snapSum;
        logic             snapCout;
        logic             snapOvf;
        exp_t             e;
        int               g;
        prevValid = 1'b0;
        prevHs    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevValid = 1'b0;
                prevHs    = 1'b0;
            end else begin
                if (prevValid && !prevHs) begin
                    checkOutput("rsp_valid_held", 64'(rsp_valid), 64'd1);
                    if (rsp_valid) begin
                        checkOutput("stall_id", 64'(rsp_id), 64'(snapId));
                        checkOutput("stall_sum", rsp_sum, snapSum);
                        checkOutput("stall_cout", 64'(rsp_cout), 64'(snapCout));
                        checkOutput("stall_ovf", 64'(rsp_ovf), 64'(snapOvf));
                    end
                end
                if (rsp_valid && !prevValid) begin
                    if (grantCyc.size() == 0) begin
                        nCompared++;
                        nMismatch++;
                        $display("[TB] FAIL rsp_without_grant: actual=valid expected=no response");
                    end else begin
                        g = grantCyc.pop_front();
                        checkOutput("latency", 64'(cycle - g), 64'(SETTLE_CYC + 1));
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    if (expQ.size() == 0) begin
                        nCompared++;
                        nMismatch++;
                        $display("[TB] FAIL unexpected_rsp: actual id=%0d sum=%h expected=none", rsp_id, rsp_sum);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
                        checkOutput("rsp_sum", rsp_sum, e.sum);
                        checkOutput("rsp_cout", 64'(rsp_cout), 64'(e.cout));
                        checkOutput("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
                    end
                end
                snapId    = rsp_id;
                snapSum   = rsp_sum;
                snapCout  = rsp_cout;
                snapOvf   = rsp_ovf;
                prevValid = rsp_valid;
                prevHs    = rsp_valid && rsp_ready;
            end
        end
    end

    // Directed test sequence
    initial begin
        op_t abortOp;
        int  n;
        nCompared = 0;
        nMismatch = 0;
        rst       = 1'b1;
        rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_add_a", add_a, 64'd0);
        checkOutput("reset_add_b", add_b, 64'd0);
        checkOutput("reset_add_cin", 64'(add_cin), 64'd0);
        checkOutput("reset_rsp_sum", rsp_sum, 64'd0);
        checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
        rst = 1'b0;

        $display("[TB] single add and wrap/overflow cases");
        applyStimulus(0, 64'd5, 64'd7, 1'b1, 1'b0, 64'd13, 1'b0, 1'b0);
        waitDone("single_add", 100);
        applyStimulus(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        waitDone("wrap", 100);
        applyStimulus(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        waitDone("overflow", 100);

        $display("[TB] subtract with cin 0 and 1");
        applyStimulus(3, 64'd3, 64'd5, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        waitDone("sub_cin0", 100);
        applyStimulus(0, 64'd3, 64'd5, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        waitDone("sub_cin1", 100);

        $display("[TB] backpressure");
        @(negedge clk);
        rsp_ready = 1'b0;
        applyStimulus(1, 64'd10, 64'd20, 1'b0, 1'b0, 64'd30, 1'b0, 1'b0);
        applyStimulus(2, 64'd100, 64'd40, 1'b0, 1'b1, 64'd60, 1'b1, 1'b0);
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_rsp_arrived", 64'(rsp_valid), 64'd1);
        repeat (10) begin
            @(negedge clk);
            checkOutput("bp_ready_zero", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_pending_accept", 64'(req_ready), 64'b0100);
        waitDone("backpressure", 100);

        $display("[TB] round robin after reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 64'd1, 64'd2, 1'b0, 1'b0, 64'd3, 1'b0, 1'b0);
        applyStimulus(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        applyStimulus(2, 64'd1, 64'd0, 1'b1, 1'b0, 64'd2, 1'b0, 1'b0);
        applyStimulus(3, 64'd0, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(0, 64'h123, 64'h456, 1'b0, 1'b0, 64'h579, 1'b0, 1'b0);
        waitDone("round_robin", 200);

        $display("[TB] reset during settle");
        @(negedge clk);
        abortOp.a = 64'h55; abortOp.b = 64'hAA; abortOp.cin = 1'b0; abortOp.sub = 1'b0;
        pend[0].push_back(abortOp);
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_op_granted", 64'(busy), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("midreset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("midreset_add_a", add_a, 64'd0);
        checkOutput("midreset_add_b", add_b, 64'd0);
        checkOutput("midreset_rsp_sum", rsp_sum, 64'd0);
        checkOutput("midreset_rsp_id", 64'(rsp_id), 64'd0);
        expQ.delete();
        grantCyc.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            checkOutput("post_reset_no_rsp", 64'(rsp_valid), 64'd0);
        end
        applyStimulus(0, 64'd7, 64'd8, 1'b0, 1'b0, 64'd15, 1'b0, 1'b0);
        applyStimulus(1, 64'd9, 64'd9, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0);
        waitDone("post_reset", 100);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
